spram_master: RTL and testbench

- Initiator side of the single-port RAM pin interface (clk, addr, tristate data, cs, we, oe).
- Accepts single-beat read/write commands on a valid/ready port.
- Sequences the RAM control pins, drives or releases the shared data bus, and returns read data on a valid/ready response port.
- Sits between a client (CPU/DMA/test sequencer) and one singleportram instance.

---
 rtl/spram_pkg.sv | 20 ++
 rtl/spram_master.sv | 140 ++++++++++++++
 tb/tb_spram_master.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/spram_pkg.sv
// Shared types and constants for the single-port RAM pin-interface master.
package spram_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_RESP  = 3'd3,
        ST_TURN  = 3'd4
    } state_t;

    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_DATA_WIDTH = 8;

    // The latency counter is loaded with READ_LAT-1, so it needs clog2(READ_LAT) bits, never fewer than one.
    function automatic int lat_cnt_width(input int read_lat);
        return (read_lat <= 2) ? 1 : $clog2(read_lat);
    endfunction

endpackage

// File: rtl/spram_master.sv
// Initiator for the single-port RAM pin interface (cs/we/oe/addr/tristate data).
// Single-beat read/write commands in on a valid/ready port, read data out on a
// valid/ready response port, one-cycle wr_ack per completed write.
// Optional build macro SPRAM_MASTER_TURNAROUND_EN: inserts a one-cycle idle
// TURN state after every write and every read response.
//
// state | meaning
// IDLE  | pins inactive, cmd_ready high
// WRITE | cs/we high, bus driven with write data for one cycle
// READ  | cs/oe high, bus released, READ_LAT cycles then sample
// RESP  | pins inactive, rsp_valid held until rsp_ready
// TURN  | one dead cycle before IDLE (turnaround build only)
module spram_master
    import spram_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int READ_LAT   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_we,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  wr_ack,
    output logic                  cs,
    output logic                  we,
    output logic                  oe,
    output logic [ADDR_WIDTH-1:0] addr,
    inout  wire  [DATA_WIDTH-1:0] data
);

    localparam int CW = lat_cnt_width(READ_LAT);
    localparam logic [CW-1:0] LAT_LOAD = CW'(READ_LAT - 1);

`ifdef SPRAM_MASTER_TURNAROUND_EN
    localparam state_t ST_AFTER = ST_TURN;
`else
    localparam state_t ST_AFTER = ST_IDLE;
`endif

    state_t                r_state;
    logic [CW-1:0]         r_cnt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_cs;
    logic                  r_we;
    logic                  r_oe;
    logic                  r_drv;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_wr_ack;
    logic                  w_accept;

    // Ready is a pure function of state, forced low while reset is held.
    always_comb begin
        cmd_ready = (r_state == ST_IDLE) && !rst;
        w_accept  = cmd_valid && cmd_ready;
    end

    // Master drives the shared bus only while in WRITE; r_drv and r_oe are never high together.
    assign data = r_drv ? r_wdata : {DATA_WIDTH{1'bz}};

    assign cs        = r_cs;
    assign we        = r_we;
    assign oe        = r_oe;
    assign addr      = r_addr;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign wr_ack    = r_wr_ack;

    // Sequencer: pins are set up on the edge that enters each state so they are glitch-free registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_cs        <= 1'b0;
            r_we        <= 1'b0;
            r_oe        <= 1'b0;
            r_drv       <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_wr_ack    <= 1'b0;
        end else begin
            r_wr_ack <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_addr  <= cmd_addr;
                        r_wdata <= cmd_wdata;
                        r_cs    <= 1'b1;
                        r_we    <= cmd_we;
                        r_oe    <= !cmd_we;
                        r_drv   <= cmd_we;
                        r_cnt   <= LAT_LOAD;
                        r_state <= cmd_we ? ST_WRITE : ST_READ;
                    end
                end
                ST_WRITE: begin
                    r_cs     <= 1'b0;
                    r_we     <= 1'b0;
                    r_drv    <= 1'b0;
                    r_wr_ack <= 1'b1;
                    r_state  <= ST_AFTER;
                end
                ST_READ: begin
                    if (r_cnt == '0) begin
                        r_rsp_rdata <= data;
                        r_cs        <= 1'b0;
                        r_oe        <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= ST_AFTER;
                    end
                end
                ST_TURN: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spram_master.sv
// Bench for spram_master: two instances (READ_LAT=1 and READ_LAT=3), each
// attached to a behavioural RAM and checked every cycle against a
// transaction-timing model (outputs computed from cycles elapsed since accept).
module tb_spram_master;

`ifdef SPRAM_MASTER_TURNAROUND_EN
    localparam int T = 1;
`else
    localparam int T = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit done [2];

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s inst%0d: got %0h expected %0h at %0t", nm, idx, act, exp, $time);
        end
    endtask

    task automatic fail_to(input string nm, input int idx);
        n_checks++;
        n_errors++;
        $display("FAIL %s inst%0d: got timeout expected handshake at %0t", nm, idx, $time);
    endtask

    for (genvar g = 0; g < 2; g++) begin : u
        localparam int L = (g == 0) ? 1 : 3;

        logic       rst = 1'b1;
        logic       cmd_valid = 1'b0;
        logic       cmd_we = 1'b0;
        logic [7:0] cmd_addr = 8'h00;
        logic [7:0] cmd_wdata = 8'h00;
        logic       rsp_ready = 1'b0;
        wire        cmd_ready, rsp_valid, wr_ack, cs, we, oe;
        wire  [7:0] rsp_rdata, addr;
        wire  [7:0] data;
        logic [7:0] ram_mem [256];
        bit         rr_rand = 1'b0;

        spram_master #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .READ_LAT(L)) dut (
            .clk(clk), .rst(rst),
            .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
            .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
            .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
            .wr_ack(wr_ack), .cs(cs), .we(we), .oe(oe), .addr(addr), .data(data)
        );

        // Behavioural single-port RAM.
        assign data = (cs && oe && !we) ? ram_mem[addr] : 8'bz;
        always @(posedge clk) if (cs && we) ram_mem[addr] <= data;

        always @(posedge clk) begin
            #1;
            if (rr_rand) rsp_ready = ($urandom_range(0, 3) != 0);
        end

        // Reference model: expectations from cycles elapsed since the accepting edge.
        bit [7:0] m_mem [256];
        bit       started = 1'b0, m_busy = 1'b0, m_kw = 1'b0, m_post_rst = 1'b0;
        int       cyc = 0, m_acc = 0, m_rh = -1, a;
        bit [7:0] m_A, m_D, m_rd, m_last;
        bit       e_cs, e_we, e_oe, e_wack, e_rv, e_rdy, e_drv;

        always @(negedge clk) begin
            cyc++;
            if (!started) begin
                if (rst) begin
                    started    = 1'b1;
                    m_busy     = 1'b0;
                    m_last     = 8'h00;
                    m_post_rst = 1'b1;
                end
            end else begin
                e_cs = 0; e_we = 0; e_oe = 0; e_wack = 0; e_rv = 0; e_drv = 0; e_rdy = 1;
                a = cyc - m_acc;
                if (m_busy) begin
                    if (m_kw) begin
                        if (a == 1) begin e_cs = 1; e_we = 1; e_drv = 1; end
                        else if (a == 2) e_wack = 1;
                        if (a < 2 + T) e_rdy = 0; else m_busy = 0;
                    end else begin
                        if (a <= L) begin e_cs = 1; e_oe = 1; end
                        else if (m_rh < 0) e_rv = 1;
                        if (a <= L || m_rh < 0 || cyc <= m_rh + T) e_rdy = 0; else m_busy = 0;
                    end
                end
                if (rst) e_rdy = 0;

                chk("cs", g, {31'b0, cs}, {31'b0, e_cs});
                chk("we", g, {31'b0, we}, {31'b0, e_we});
                chk("oe", g, {31'b0, oe}, {31'b0, e_oe});
                chk("wr_ack", g, {31'b0, wr_ack}, {31'b0, e_wack});
                chk("rsp_valid", g, {31'b0, rsp_valid}, {31'b0, e_rv});
                chk("cmd_ready", g, {31'b0, cmd_ready}, {31'b0, e_rdy});
                chk("addr", g, {24'b0, addr}, {24'b0, m_last});
                if (e_rv) chk("rsp_rdata", g, {24'b0, rsp_rdata}, {24'b0, m_rd});
                else if (m_post_rst) chk("rsp_rdata_rst", g, {24'b0, rsp_rdata}, 32'h0);
                if (e_drv) chk("bus_wr", g, {24'b0, data}, {24'b0, m_D});
                else if (e_oe) chk("bus_rd", g, {24'b0, data}, {24'b0, m_rd});
                m_post_rst = 1'b0;

                if (e_rv && rsp_ready) m_rh = cyc;
                if (rst) begin
                    m_busy     = 1'b0;
                    m_last     = 8'h00;
                    m_post_rst = 1'b1;
                end else if (!m_busy && e_rdy && cmd_valid) begin
                    m_busy = 1'b1;
                    m_kw   = cmd_we;
                    m_A    = cmd_addr;
                    m_D    = cmd_wdata;
                    m_acc  = cyc;
                    m_rh   = -1;
                    m_last = cmd_addr;
                    if (cmd_we) m_mem[cmd_addr] = cmd_wdata;
                    m_rd   = m_mem[cmd_addr];
                end
            end
        end

        task automatic send(input bit w, input bit [7:0] ad, input bit [7:0] d, output longint t_acc);
            int k;
            cmd_valid = 1'b1; cmd_we = w; cmd_addr = ad; cmd_wdata = d;
            k = 0;
            t_acc = 0;
            while (1) begin
                @(negedge clk);
                if (cmd_ready) break;
                k++;
                if (k > 60) begin fail_to("cmd_timeout", g); break; end
            end
            t_acc = longint'($time);
            @(posedge clk); #1;
            cmd_valid = 1'b0; cmd_we = 1'($urandom); cmd_addr = 8'($urandom); cmd_wdata = 8'($urandom);
        endtask

        task automatic get_rsp(input int hold, output bit [7:0] rd);
            int k;
            k = 0;
            rd = 8'h00;
            while (1) begin
                @(negedge clk);
                if (rsp_valid) break;
                k++;
                if (k > 60) begin fail_to("rsp_timeout", g); return; end
            end
            repeat (hold + 1) begin @(posedge clk); #1; end
            rsp_ready = 1'b1;
            @(negedge clk);
            rd = rsp_rdata;
            @(posedge clk); #1;
            rsp_ready = 1'b0;
        endtask

        initial begin
            longint t1, t2, t3, tx;
            bit [7:0] rd;
            bit w;
            bit [7:0] ad, d;
            int k;
            for (int i = 0; i < 256; i++) ram_mem[i] = 8'h00;
            repeat (3) begin @(posedge clk); #1; end
            rst = 1'b0;

            // Write then read back.
            send(1'b1, 8'h01, 8'hA5, tx);
            send(1'b0, 8'h01, 8'h00, tx);
            get_rsp(0, rd);
            chk("readback_a5", g, {24'b0, rd}, 32'hA5);

            // Back-to-back writes, spacing of accepts.
            send(1'b1, 8'h00, 8'h11, t1);
            send(1'b1, 8'hFF, 8'h22, t2);
            send(1'b1, 8'h80, 8'h33, t3);
            chk("wr_spacing1", g, 32'((t2 - t1) / 10), 32'(2 + T));
            chk("wr_spacing2", g, 32'((t3 - t2) / 10), 32'(2 + T));
            send(1'b0, 8'h00, 8'h00, tx);
            get_rsp(0, rd);
            chk("read_00", g, {24'b0, rd}, 32'h11);
            send(1'b0, 8'hFF, 8'h00, tx);
            get_rsp(4, rd);
            chk("read_ff_bp", g, {24'b0, rd}, 32'h22);
            send(1'b0, 8'h80, 8'h00, tx);
            get_rsp(1, rd);
            chk("read_80", g, {24'b0, rd}, 32'h33);

            // Command presented during WRITE must not be captured.
            send(1'b1, 8'h40, 8'h77, tx);
            cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 8'h05; cmd_wdata = 8'hEE;
            @(posedge clk); #1;
            cmd_valid = 1'b0;
            send(1'b0, 8'h05, 8'h00, tx);
            get_rsp(0, rd);
            chk("busy_ignored", g, {24'b0, rd}, 32'h00);

            // Reset during READ.
            send(1'b0, 8'h01, 8'h00, tx);
            rst = 1'b1;
            @(negedge clk);
            chk("rst_ready0", g, {31'b0, cmd_ready}, 32'h0);
            @(posedge clk); #1;
            @(negedge clk);
            chk("rst_cs", g, {29'b0, cs, oe, rsp_valid}, 32'h0);
            @(posedge clk); #1;
            rst = 1'b0;
            @(negedge clk);
            chk("rst_release_ready", g, {31'b0, cmd_ready}, 32'h1);
            @(posedge clk); #1;

            // Randomized traffic with random response backpressure.
            rr_rand = 1'b1;
            for (int n = 0; n < 150; n++) begin
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                w  = 1'($urandom_range(0, 1));
                ad = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
                d  = 8'($urandom);
                send(w, ad, d, tx);
            end
            k = 0;
            while (1) begin
                @(negedge clk);
                if (cmd_ready) break;
                k++;
                if (k > 60) begin fail_to("drain_timeout", g); break; end
            end
            rr_rand = 1'b0;
            done[g] = 1'b1;
        end
    end

    initial begin
        int k;
        k = 0;
        while (!(done[0] && done[1])) begin
            @(posedge clk);
            k++;
            if (k > 20000) begin
                fail_to("global_timeout", 0);
                break;
            end
        end
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
